// File: rtl/code_rx_controller.sv
// rtl/code_rx_controller.sv - serial frame sequencer with Hamming(7,4) decode and 2-entry output FIFO
module code_rx_controller #(
    parameter int FRAME_BITS = 8,
    parameter int RX_LATENCY = 1,
    parameter int MIN_GAP    = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_input,
    input  logic [7:0] rx_data,
    output logic       rx_clear,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic       out_corrected,
    output logic [2:0] out_syndrome,
    output logic [7:0] frame_err_cnt,
    output logic [7:0] overflow_cnt
);

    typedef enum logic [2:0] {IDLE, RECV, WAIT, CAPTURE, GAP} state_t;

    localparam logic [4:0] BIT_LAST  = 5'(FRAME_BITS);
    localparam logic [4:0] WAIT_LAST = 5'((RX_LATENCY > 0) ? RX_LATENCY - 1 : 0);
    localparam logic [3:0] GAP_LAST  = 4'(MIN_GAP);

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [3:0] gap_q, gap_d;
    logic [7:0] head_q, head_d;
    logic       head_valid_q, head_valid_d;
    logic [7:0] tail_q, tail_d;
    logic       tail_valid_q, tail_valid_d;
    logic [7:0] ferr_q, ferr_d;
    logic [7:0] ovf_q, ovf_d;

    logic       capture;
    logic       gap_err;
    logic [7:1] pos;
    logic [7:1] fixed;
    logic [2:0] syn;
    logic [7:0] new_entry;
    logic       pop, push_req, push, full, ovf_inc, ferr_inc;

    // Entry layout: {data[3:0], corrected, syndrome[2:0]}
    always_comb begin
        pos = {rx_data[0], rx_data[1], rx_data[2], rx_data[3],
               rx_data[4], rx_data[5], rx_data[6]};
        syn = {pos[4] ^ pos[5] ^ pos[6] ^ pos[7],
               pos[2] ^ pos[3] ^ pos[6] ^ pos[7],
               pos[1] ^ pos[3] ^ pos[5] ^ pos[7]};
        for (int i = 1; i <= 7; i++) begin
            fixed[i] = pos[i] ^ (syn == 3'(i));
        end
        new_entry = {fixed[3], fixed[5], fixed[6], fixed[7], |syn, syn};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        capture = 1'b0;
        gap_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (io_input) begin
                    state_d = RECV;
                    cnt_d   = 5'd1;
                end
            end
            RECV: begin
                if (cnt_q + 5'd1 == BIT_LAST) begin
                    cnt_d   = 5'd0;
                    state_d = (RX_LATENCY == 0) ? CAPTURE : WAIT;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = CAPTURE;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            CAPTURE: begin
                capture = 1'b1;
                state_d = GAP;
                gap_d   = 4'd0;
            end
            GAP: begin
                // Any high restarts the quiet-time requirement from zero.
                if (io_input) begin
                    gap_err = 1'b1;
                    gap_d   = 4'd0;
                end else if (gap_q + 4'd1 == GAP_LAST) begin
                    state_d = IDLE;
                    gap_d   = 4'd0;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop          = head_valid_q & out_ready;
        push_req     = capture & rx_data[7];
        full         = head_valid_q & tail_valid_q;
        push         = push_req & (~full | pop);
        ovf_inc      = push_req & full & ~pop;
        ferr_inc     = (capture & ~rx_data[7]) | gap_err;
        head_d       = head_q;
        head_valid_d = head_valid_q;
        tail_d       = tail_q;
        tail_valid_d = tail_valid_q;
        if (pop) begin
            if (tail_valid_q) begin
                head_d       = tail_q;
                head_valid_d = 1'b1;
                tail_valid_d = push;
                if (push) tail_d = new_entry;
            end else begin
                head_valid_d = push;
                if (push) head_d = new_entry;
            end
        end else if (push) begin
            if (!head_valid_q) begin
                head_d       = new_entry;
                head_valid_d = 1'b1;
            end else begin
                tail_d       = new_entry;
                tail_valid_d = 1'b1;
            end
        end
        ferr_d = (ferr_inc && ferr_q != 8'hFF) ? ferr_q + 8'd1 : ferr_q;
        ovf_d  = (ovf_inc && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= 5'd0;
            gap_q        <= 4'd0;
            head_q       <= 8'd0;
            head_valid_q <= 1'b0;
            tail_q       <= 8'd0;
            tail_valid_q <= 1'b0;
            ferr_q       <= 8'd0;
            ovf_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
            tail_q       <= tail_d;
            tail_valid_q <= tail_valid_d;
            ferr_q       <= ferr_d;
            ovf_q        <= ovf_d;
        end
    end

    assign rx_clear      = (state_q == CAPTURE);
    assign out_valid     = head_valid_q;
    assign out_data      = head_q[7:4];
    assign out_corrected = head_q[3];
    assign out_syndrome  = head_q[2:0];
    assign frame_err_cnt = ferr_q;
    assign overflow_cnt  = ovf_q;

endmodule
